// File: rtl/hps_status_event_conditioner.sv
// Conditions raw HPS read-status events (level / stretched pulse / toggle) for the PIO in_port.
// Optional 2-flop input synchroniser when HPS_STATUS_SYNC_EN is defined.
module hps_status_event_conditioner #(
  parameter int unsigned      WIDTH        = 8,
  parameter int unsigned      HOLD_CYCLES  = 4,
  parameter int unsigned      CNT_W        = 3,
  parameter logic [WIDTH-1:0] STRETCH_MASK = '0,
  parameter logic [WIDTH-1:0] TOGGLE_MASK  = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] event_in,
  input  logic             clr_overrun,
  output logic [WIDTH-1:0] status_out,
  output logic [WIDTH-1:0] overrun
);

  localparam logic [CNT_W-1:0] HoldVal = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

  logic [WIDTH-1:0] ev;
  logic [WIDTH-1:0] ev_q;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] status_d, status_q;
  logic [WIDTH-1:0] ovr_d, ovr_q;
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [CNT_W-1:0] cnt_q [WIDTH];

`ifdef HPS_STATUS_SYNC_EN
  logic [WIDTH-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= event_in;
      sync2_q <= sync1_q;
    end
  end

  assign ev = sync2_q;
`else
  assign ev = event_in;
`endif

  assign rise = ev & ~ev_q;

  always_comb begin
    ovr_d    = clr_overrun ? '0 : ovr_q;
    status_d = status_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (TOGGLE_MASK[i]) begin
        if (rise[i]) status_d[i] = ~status_q[i];
      end else if (STRETCH_MASK[i]) begin
        if (rise[i]) begin
          cnt_d[i]    = HoldVal;
          status_d[i] = 1'b1;
          // Retrigger while still holding; applied after the clear so a set wins.
          if (cnt_q[i] != '0) ovr_d[i] = 1'b1;
        end else if (cnt_q[i] != '0) begin
          cnt_d[i]    = cnt_q[i] - CntOne;
          status_d[i] = (cnt_q[i] != CntOne);
        end else begin
          status_d[i] = 1'b0;
        end
      end else begin
        status_d[i] = ev[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ev_q     <= '0;
      status_q <= '0;
      ovr_q    <= '0;
      cnt_q    <= '{default: '0};
    end else begin
      ev_q     <= ev;
      status_q <= status_d;
      ovr_q    <= ovr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign status_out = status_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_hps_status_event_conditioner.sv
// Directed self-checking bench: bit 0 stretch, bit 7 toggle, bits 1..6 level.
module tb_hps_status_event_conditioner;

`ifdef HPS_STATUS_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk;
  logic       reset_n;
  logic [7:0] event_in;
  logic       clr_overrun;
  logic [7:0] status_out;
  logic [7:0] overrun;

  int checks;
  int failures;
  int edges;
  int rel;
  logic prev7;
  logic exp_b;

  hps_status_event_conditioner #(
    .WIDTH       (8),
    .HOLD_CYCLES (4),
    .CNT_W       (3),
    .STRETCH_MASK(8'h01),
    .TOGGLE_MASK (8'h80)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .event_in   (event_in),
    .clr_overrun(clr_overrun),
    .status_out (status_out),
    .overrun    (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change just after a falling edge; outputs are sampled at the next falling edge.
  task automatic step(input logic [7:0] ev, input logic clr);
    event_in    = ev;
    clr_overrun = clr;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset_n     = 1'b0;
    event_in    = 8'h00;
    clr_overrun = 1'b0;

    // Reset held with all inputs high.
    for (int k = 0; k < 3; k++) begin
      step(8'hFF, 1'b0);
      chk("reset_status", status_out, 8'h00);
      chk("reset_overrun", overrun, 8'h00);
    end

    // Release with inputs still high: every mode sees a rise, then the held level.
    reset_n = 1'b1;
    for (int k = 0; k < 5 + LAT; k++) begin
      step(8'hFF, 1'b0);
      if (k + 1 == 1 + LAT) chk("release_first", status_out, 8'hFF);
      if (k + 1 == 4 + LAT) chk("release_hold_end", status_out, 8'hFF);
      if (k + 1 == 5 + LAT) chk("release_stretch_done", status_out, 8'hFE);
    end
    for (int k = 0; k < 2 + LAT; k++) step(8'h00, 1'b0);
    chk("level_drop_toggle_keeps", status_out, 8'h80);
    chk("release_overrun", overrun, 8'h00);

    reset_n = 1'b0;
    step(8'h00, 1'b0);
    reset_n = 1'b1;
    chk("reset_clears_toggle", status_out, 8'h00);

    // Single stretch pulse.
    for (int k = 0; k < 8 + LAT; k++) begin
      step((k == 0) ? 8'h01 : 8'h00, 1'b0);
      rel = k + 1 - LAT;
      exp_b = (rel >= 1 && rel <= 4);
      chk("stretch_status", status_out, {7'b0, exp_b});
    end
    chk("stretch_overrun", overrun, 8'h00);

    // Retrigger two cycles after the first pulse, then clear the overrun.
    for (int k = 0; k < 12 + LAT; k++) begin
      step((k == 0 || k == 2) ? 8'h01 : 8'h00, (k == 10));
      rel = k + 1 - LAT;
      exp_b = (rel >= 1 && rel <= 6);
      chk("retrig_status", status_out, {7'b0, exp_b});
      exp_b = (k + 1 >= 3 + LAT) && (k + 1 < 11);
      chk("retrig_overrun", overrun, {7'b0, exp_b});
    end

    // Retrigger lands on the same edge as the clear: the set must win.
    for (int k = 0; k < 10 + LAT; k++) begin
      step((k == 0 || k == 2) ? 8'h01 : 8'h00, (k == 2 + LAT) || (k == 8 + LAT));
      if (k + 1 == 3 + LAT) chk("set_beats_clear", overrun, 8'h01);
      if (k + 1 == 9 + LAT) chk("clear_after_set", overrun, 8'h00);
    end

    // Toggle: three rises on bit 7, the third held high afterwards.
    edges = 0;
    prev7 = status_out[7];
    for (int k = 0; k < 10 + LAT; k++) begin
      step((k == 0 || k == 2 || k >= 4) ? 8'h80 : 8'h00, 1'b0);
      rel = k + 1 - LAT;
      exp_b = (rel >= 5) ? 1'b1 : (rel >= 3) ? 1'b0 : (rel >= 1) ? 1'b1 : 1'b0;
      chk("toggle_status", status_out, {exp_b, 7'b0});
      if (status_out[7] !== prev7) edges++;
      prev7 = status_out[7];
    end
    checks++;
    assert (edges == 3)
    else begin
      failures++;
      $error("FAIL toggle_edge_count observed=%0d expected=3", edges);
    end
    chk("toggle_overrun", overrun, 8'h00);
    for (int k = 0; k < 2 + LAT; k++) step(8'h00, 1'b0);
    chk("toggle_stays_after_drop", status_out, 8'h80);

    // Reset in the middle of a stretch (counter at 3) aborts it.
    for (int k = 0; k < 2 + LAT; k++) step((k == 0) ? 8'h01 : 8'h00, 1'b0);
    chk("midhold_before_reset", status_out, 8'h81);
    reset_n = 1'b0;
    step(8'h00, 1'b0);
    reset_n = 1'b1;
    chk("midhold_reset_status", status_out, 8'h00);
    chk("midhold_reset_overrun", overrun, 8'h00);
    for (int k = 0; k < 6; k++) begin
      step(8'h00, 1'b0);
      chk("midhold_no_residual", status_out, 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
